// File: rtl/seg_display_mux_if.sv
// seg_display_mux_if: load/display bundle for seg_display_mux.
//   value    : binary number to convert (sampled on an accepted load)
//   load     : one-cycle convert request
//   blank_lz : blank leading zeros
//   blink    : blink the whole display
//   dp_mask  : per-digit decimal point enables (bit 0 = least significant)
//   busy     : conversion in progress, load ignored
//   ovf      : last accepted value does not fit in NUM_DIGITS digits
//   an       : active-low digit enables
//   seg      : active-low segments {g,f,e,d,c,b,a}
//   dp       : active-low decimal point
interface seg_display_mux_if #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
);
  logic [VALUE_W-1:0]    value;
  logic                  load;
  logic                  blank_lz;
  logic                  blink;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic                  busy;
  logic                  ovf;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;

  modport master (
    output value, load, blank_lz, blink, dp_mask,
    input  busy, ovf, an, seg, dp
  );

  modport slave (
    input  value, load, blank_lz, blink, dp_mask,
    output busy, ovf, an, seg, dp
  );
endinterface

// File: rtl/seg_display_mux.sv
// seg_display_mux: binary-to-BCD converter (double dabble, one bit per cycle)
// driving a time-multiplexed, active-low 7-segment display.
//   clk : sole clock, rising edge
//   rst : synchronous reset, active-high
//   bus : seg_display_mux_if.slave (value/load/blank_lz/blink/dp_mask in,
//         busy/ovf/an/seg/dp out)
// Parameters: NUM_DIGITS (1..8), VALUE_W (1..27), DWELL_W (digit dwell is
// 2^DWELL_W cycles), BLINK_W (blink period 2^BLINK_W cycles, 50% duty).

// Per-digit segment encoder with leading-zero and overflow handling.
//   digit     : BCD digit to show
//   lead_zero : this digit and all more-significant digits are zero
//   ovf       : show '-' instead of the digit
//   blank_lz  : leading-zero blanking enable
//   seg       : active-low segments {g,f,e,d,c,b,a}
module seg_digit_lane (
  input  logic [3:0] digit,
  input  logic       lead_zero,
  input  logic       ovf,
  input  logic       blank_lz,
  output logic [6:0] seg
);
  logic [6:0] enc;

  always_comb begin
    case (digit)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'h7F;
    endcase
  end

  // Overflow dash overrides blanking so every position shows '-'.
  always_comb begin
    if (ovf)                        seg = 7'b0111111;
    else if (blank_lz && lead_zero) seg = 7'h7F;
    else                            seg = enc;
  end
endmodule

module seg_display_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14,
  parameter int DWELL_W    = 14,
  parameter int BLINK_W    = 25
) (
  input logic               clk,
  input logic               rst,
  seg_display_mux_if.slave  bus
);
  // Conversion register holds enough BCD digits for any VALUE_W-bit number
  // (10^ceil(W/3) >= 2^W) so overflow is simply a nonzero upper digit.
  localparam int BCD_RAW = (VALUE_W + 2) / 3;
  localparam int BCD_D   = (BCD_RAW > NUM_DIGITS) ? BCD_RAW : NUM_DIGITS;
  localparam int BCD_W   = 4 * BCD_D;
  localparam int CNT_W   = $clog2(VALUE_W + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // ---------------- conversion engine ----------------
  logic [VALUE_W-1:0]            shreg;
  logic [BCD_D-1:0][3:0]         bcd;
  logic [BCD_D-1:0][3:0]         bcd_adj;
  logic [BCD_D-1:0][3:0]         bcd_next;
  logic [BCD_W:0]                shifted;
  logic [CNT_W-1:0]              bit_cnt;
  logic                          busy_q;
  logic                          ovf_q;
  logic                          ovf_next;
  logic [NUM_DIGITS-1:0][3:0]    dig_q;

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < BCD_D; d++)
      if (bcd[d] > 4'd4) bcd_adj[d] = bcd[d] + 4'd3;
  end

  assign shifted  = {bcd_adj, shreg[VALUE_W-1]};
  assign bcd_next = shifted[BCD_W-1:0];

  // Bit shifted out of the top can only be set on overflow; fold it in.
  always_comb begin
    ovf_next = shifted[BCD_W];
    for (int d = NUM_DIGITS; d < BCD_D; d++)
      ovf_next = ovf_next | (bcd_next[d] != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
    end else if (!busy_q) begin
      if (bus.load) begin
        shreg   <= bus.value;
        bcd     <= '0;
        bit_cnt <= '0;
        busy_q  <= 1'b1;
      end
    end else begin
      shreg   <= shreg << 1;
      bcd     <= bcd_next;
      bit_cnt <= bit_cnt + 1'b1;
      // Final step: publish digits and overflow together as busy drops.
      if (bit_cnt == CNT_W'(VALUE_W - 1)) begin
        busy_q <= 1'b0;
        dig_q  <= bcd_next[NUM_DIGITS-1:0];
        ovf_q  <= ovf_next;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.ovf  = ovf_q;

  // ---------------- per-digit encoders ----------------
  // lead_z[g]: digits g..NUM_DIGITS-1 all zero. Digit 0 is never blanked.
  logic [NUM_DIGITS:1]        lead_z;
  logic [NUM_DIGITS-1:0][6:0] lane_seg;

  assign lead_z[NUM_DIGITS] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    if (g > 0) begin : g_lz
      assign lead_z[g] = lead_z[g+1] & (dig_q[g] == 4'd0);
    end
    seg_digit_lane u_lane (
      .digit     (dig_q[g]),
      .lead_zero ((g > 0) ? lead_z[(g > 0) ? g : 1] : 1'b0),
      .ovf       (ovf_q),
      .blank_lz  (bus.blank_lz),
      .seg       (lane_seg[g])
    );
  end

  // ---------------- scan and blink ----------------
  logic [DWELL_W-1:0] dwell;
  logic [BLINK_W-1:0] blink_cnt;
  logic [IDX_W-1:0]   idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell     <= '0;
      blink_cnt <= '0;
      idx       <= '0;
    end else begin
      dwell     <= dwell + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      if (&dwell)
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // ---------------- output registers ----------------
  logic [NUM_DIGITS-1:0] an_nx;
  logic [6:0]            seg_nx;
  logic                  dp_nx;
  logic                  blink_off;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;

  assign blink_off = bus.blink & blink_cnt[BLINK_W-1];

  always_comb begin
    an_nx  = '1;
    seg_nx = 7'h7F;
    dp_nx  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        an_nx[i] = 1'b0;
        seg_nx   = lane_seg[i];
        dp_nx    = ~bus.dp_mask[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || blink_off) begin
      an_q  <= '1;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_nx;
      seg_q <= seg_nx;
      dp_q  <= dp_nx;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
endmodule

// File: tb/tb_seg_display_mux.sv
module tb_seg_display_mux;
  localparam int ND = 4;
  localparam int VW = 14;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000,
                         SB = 7'h7F,      SD = 7'b0111111;

  // kind: 0 conversion (checked when busy falls), 1 scan, 2 blink, 3 reset
  typedef struct packed {
    logic [1:0]      kind;
    logic            exp_ovf;
    logic [3:0]      dpm;
    logic [3:0][6:0] sg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_display_mux_if #(.NUM_DIGITS(ND), .VALUE_W(VW)) bus ();

  seg_display_mux #(.NUM_DIGITS(ND), .VALUE_W(VW), .DWELL_W(2), .BLINK_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sbq[$];
  int   checks = 0, errors = 0;
  int   req_cnt = 0, done_cnt = 0, issued = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i] == 1'b0) return i;
    return 0;
  endfunction

  // Check one full scan (4 digits x 4 cycles) starting at the next digit change.
  task automatic scan_check(exp_t e);
    logic [3:0] a0;
    logic [3:0] ea;
    logic       edp;
    int         w, first, ei;
    a0 = bus.an;
    w  = 0;
    while (bus.an == a0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) begin
      checks++;
      errors++;
      $display("FAIL scan_start actual=timeout required=digit_change");
    end
    first = idx_of(bus.an);
    for (int k = 0; k < 16; k++) begin
      ei  = (first + k / 4) % 4;
      ea  = ~(4'b0001 << ei);
      edp = ~e.dpm[ei];
      chk("scan_an",  bus.an,  ea);
      chk("scan_seg", bus.seg, e.sg[ei]);
      chk("scan_dp",  bus.dp,  edp);
      @(negedge clk);
    end
  endtask

  task automatic blink_check(exp_t e);
    int   off;
    int   i;
    logic edp;
    off = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      if (bus.an == 4'hF) begin
        off++;
        chk("blink_seg_off", bus.seg, SB);
        chk("blink_dp_off",  bus.dp,  1);
      end else begin
        i   = idx_of(bus.an);
        edp = ~e.dpm[i];
        chk("blink_an_onehot", $countones(~bus.an), 1);
        chk("blink_seg_on",    bus.seg, e.sg[i]);
        chk("blink_dp_on",     bus.dp,  edp);
      end
      @(negedge clk);
    end
    chk("blink_off_cycles", off, 16);
  endtask

  // Monitor: pops the scoreboard when a conversion completes or a check is requested.
  initial begin : monitor
    exp_t e;
    logic pb;
    int   bcnt, seen;
    pb = 1'b0; bcnt = 0; seen = 0;
    forever begin
      @(negedge clk);
      if (pb && !bus.busy && !rst) begin
        if (sbq.size() == 0 || sbq[0].kind != 2'd0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_conversion actual=busy_fall required=none");
        end else begin
          e = sbq.pop_front();
          chk("busy_len", bcnt, VW);
          chk("conv_ovf", bus.ovf, e.exp_ovf);
          scan_check(e);
        end
        done_cnt++;
        bcnt = 0;
      end else if (req_cnt > seen) begin
        seen++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL empty_scoreboard actual=0 required=entry");
        end else begin
          e = sbq.pop_front();
          case (e.kind)
            2'd3: begin
              chk("rst_an",   bus.an,   4'hF);
              chk("rst_seg",  bus.seg,  SB);
              chk("rst_dp",   bus.dp,   1);
              chk("rst_busy", bus.busy, 0);
              chk("rst_ovf",  bus.ovf,  0);
            end
            2'd2:    blink_check(e);
            default: begin
              chk("scan_ovf", bus.ovf, e.exp_ovf);
              scan_check(e);
            end
          endcase
        end
        done_cnt++;
      end
      pb = bus.busy;
      if (rst) bcnt = 0;
      else if (bus.busy) bcnt++;
    end
  end

  task automatic push(logic [1:0] kind, logic ov, logic [3:0] dpm, logic [3:0][6:0] sg);
    exp_t e;
    e.kind = kind; e.exp_ovf = ov; e.dpm = dpm; e.sg = sg;
    sbq.push_back(e);
    issued++;
    if (kind != 2'd0) req_cnt++;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (done_cnt < issued && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (done_cnt < issued) begin
      checks++;
      errors++;
      $display("FAIL wait_done actual=%0d required=%0d", done_cnt, issued);
      done_cnt = issued;
    end
  endtask

  task automatic do_load(logic [VW-1:0] v);
    @(posedge clk); #1;
    bus.value = v;
    bus.load  = 1'b1;
    @(posedge clk); #1;
    bus.load  = 1'b0;
  endtask

  task automatic conv(logic [VW-1:0] v, logic ov, logic [3:0][6:0] sg);
    push(2'd0, ov, bus.dp_mask, sg);
    do_load(v);
    wait_done();
  endtask

  initial begin : stim
    rst = 1'b1;
    bus.value = '0; bus.load = 1'b0; bus.blank_lz = 1'b0;
    bus.blink = 1'b0; bus.dp_mask = '0;
    repeat (3) @(posedge clk); #1;
    push(2'd3, 0, 4'b0000, {SB, SB, SB, SB});
    wait_done();

    // After reset: zeros, then a single '0' with blanking
    rst = 1'b0;
    push(2'd1, 0, 4'b0000, {S0, S0, S0, S0});
    wait_done();
    bus.blank_lz = 1'b1;
    push(2'd1, 0, 4'b0000, {SB, SB, SB, S0});
    wait_done();
    bus.blank_lz = 1'b0;

    conv(14'd1234, 0, {S1, S2, S3, S4});
    conv(14'd9999, 0, {S9, S9, S9, S9});
    conv(14'd10000, 1, {SD, SD, SD, SD});
    // Overflow ignores blanking but keeps decimal points
    bus.blank_lz = 1'b1; bus.dp_mask = 4'b0101;
    push(2'd1, 1, 4'b0101, {SD, SD, SD, SD});
    wait_done();
    bus.dp_mask = 4'b0000;

    conv(14'd7,    0, {SB, SB, SB, S7});
    conv(14'd0,    0, {SB, SB, SB, S0});
    conv(14'd1005, 0, {S1, S0, S0, S5});
    conv(14'd20,   0, {SB, SB, S2, S0});
    bus.blank_lz = 1'b0;

    // Second load mid-conversion is ignored
    push(2'd0, 0, 4'b0000, {S1, S2, S3, S4});
    do_load(14'd1234);
    repeat (3) @(posedge clk); #1;
    bus.value = 14'd5678; bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    wait_done();

    // Reset at cycle 5 of a conversion aborts it and clears the digits
    do_load(14'd4321);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    push(2'd3, 0, 4'b0000, {SB, SB, SB, SB});
    wait_done();
    rst = 1'b0;
    push(2'd1, 0, 4'b0000, {S0, S0, S0, S0});
    wait_done();

    // Blink with a decimal point on digit 1
    conv(14'd1234, 0, {S1, S2, S3, S4});
    bus.dp_mask = 4'b0010; bus.blink = 1'b1;
    push(2'd2, 0, 4'b0010, {S1, S2, S3, S4});
    wait_done();
    bus.blink = 1'b0; bus.dp_mask = 4'b0000;

    // Reset wins over a simultaneous load; load accepted on first free edge
    @(posedge clk); #1;
    rst = 1'b1; bus.value = 14'd42; bus.load = 1'b1;
    @(posedge clk); #1;
    push(2'd3, 0, 4'b0000, {SB, SB, SB, SB});
    wait_done();
    push(2'd0, 0, 4'b0000, {S0, S0, S4, S2});
    rst = 1'b0;
    @(posedge clk); #1;
    bus.load = 1'b0;
    wait_done();

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed 7-segment digits, legal range 1..8.
REQ-002 Parameter VALUE_W, default 14: width of the binary input value, legal range 1..27.
REQ-003 Parameter DWELL_W, default 14: each digit is lit for 2^DWELL_W clk cycles.
REQ-004 Parameter BLINK_W, default 25: blink period is 2^BLINK_W clk cycles, 50% duty.
REQ-005 clk  input  1  sole clock, all state updates on its rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 value  input  VALUE_W  unsigned binary number to display, sampled only on an accepted load.
REQ-008 load  input  1  one-cycle request to convert and display value.
REQ-009 blank_lz  input  1  1 = blank leading zeros.
REQ-010 blink  input  1  1 = blink the whole display.
REQ-011 dp_mask  input  NUM_DIGITS  bit i = 1 lights the decimal point of digit i (digit 0 = least significant).
REQ-012 busy  output  1  conversion in progress, load ignored.
REQ-013 ovf  output  1  the last accepted value exceeds 10^NUM_DIGITS-1.
REQ-014 an  output  NUM_DIGITS  digit enables, active-low, one-hot-low when lit.
REQ-015 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-016 dp  output  1  decimal point, active-low.

Function
REQ-017 Load accepted when load=1 and busy=0; value captured on that edge; load while busy=1 has no effect.
REQ-018 Conversion uses a shift-add-3 (double-dabble) engine with one input bit per cycle; busy=1 for exactly VALUE_W cycles starting the cycle after acceptance.
REQ-019 The displayed digit register updates atomically on the edge where busy falls; until then the previous digits remain shown.
REQ-020 ovf updates on the same edge as the digit register; when ovf=1 every digit shows '-' (seg=7'b0111111), leading-zero blanking is inactive, and dp_mask still applies.
REQ-021 Scan: DWELL_W-bit dwell counter free-runs; digit index increments when the counter wraps to 0 and wraps from NUM_DIGITS-1 to 0; there are no blank slots.
REQ-022 an, seg and dp are registered and reflect the digit index one cycle after the index changes.
REQ-023 Encoding, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 With blank_lz=1, a digit is blanked (seg=7'h7F) when it and every more-significant digit are 0; digit 0 is never blanked, so value 0 shows a single '0'.
REQ-025 A blanked digit still drives its an bit low; dp follows dp_mask for that digit.
REQ-026 BLINK_W-bit blink counter free-runs; while blink=1 and the counter MSB=1, an=all ones and seg, dp=all ones; scan continues underneath.
REQ-027 blank_lz, blink and dp_mask take effect at the next output register update, without waiting for a load.
REQ-028 The scan does not stall or reset during conversion.

Reset
REQ-029 While rst=1 on an edge: an=all ones, seg=7'h7F, dp=1, busy=0, ovf=0, digit register=all zeros, dwell, blink and digit index counters=0, and any conversion in flight is aborted.
REQ-030 rst takes priority over a simultaneous load; the first load can be accepted on the first edge with rst=0.
REQ-031 After reset release with no load, the display shows zeros, or a single '0' when blank_lz=1.

Verification
REQ-032 Parameters NUM_DIGITS=4, VALUE_W=14, DWELL_W=2: load value=1234 -> busy high for 14 cycles, then the scan shows seg codes for 4,3,2,1 on an=1110,1101,1011,0111 with each held 4 cycles.
REQ-033 value=9999 then value=10000 with VALUE_W=14 -> 9999 displays with ovf=0; 10000 sets ovf=1 and all digits show 0111111.
REQ-034 blank_lz=1 and value=7 -> digits 3..1 seg=7'h7F with an still cycling, digit 0 shows 1111000; value=0 -> digit 0 shows 1000000.
REQ-035 load pulsed again mid-conversion with a different value -> ignored, the first value is displayed, and busy length is unchanged.
REQ-036 rst asserted at cycle 5 of a conversion -> all outputs take reset values next cycle, and the old digits are not restored.
REQ-037 BLINK_W=4, blink=1, dp_mask=0010 -> an=1111 for 8 of every 16 cycles; dp=0 only while an=1101 and the display is not blanked.
